// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing generator (640x480@60 by default).
// Divides Clk down to a pixel enable, runs the horizontal/vertical scan
// counters and decodes sync, blanking and line/frame strobes.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high
//   pix_en       pixel enable, high one Clk in every PIX_DIV
//   DrawX/DrawY  raw scan counts (including blanking)
//   VGA_HS/VS    active-low syncs, registered with the counts
//   blank_n      high inside the visible region
//   line_end     one-Clk pulse on the last pixel of each line
//   frame_end    one-Clk pulse on the last pixel of each frame
//   frame_count  frames completed since reset, 8-bit wrap
module vga_scan_gen #(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_VIS   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       blank_n,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VIS + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             blank_nxt;
    logic [7:0]       fc_nxt;

    // Pixel divider; with PIX_DIV=1 the counter is pinned at 0 and pix_en stays high.
    always_ff @(posedge Clk) begin
        if (Reset || (div_cnt == DIV_W'(PIX_DIV - 1))) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign pix_en    = (div_cnt == DIV_W'(PIX_DIV - 1));
    assign line_end  = pix_en && (DrawX == 10'(H_TOTAL - 1));
    assign frame_end = line_end && (DrawY == 10'(V_TOTAL - 1));

    // Next scan position; syncs/blank decode from the updated counts so they
    // change on the same edge as DrawX/DrawY.
    always_comb begin
        h_nxt     = DrawX;
        v_nxt     = DrawY;
        hs_nxt    = VGA_HS;
        vs_nxt    = VGA_VS;
        blank_nxt = blank_n;
        fc_nxt    = frame_count;

        if (pix_en) begin
            if (DrawX == 10'(H_TOTAL - 1)) begin
                h_nxt = '0;
                if (DrawY == 10'(V_TOTAL - 1)) begin
                    v_nxt = '0;
                end else begin
                    v_nxt = DrawY + 10'd1;
                end
            end else begin
                h_nxt = DrawX + 10'd1;
            end
            hs_nxt    = !((h_nxt >= 10'(HS_START)) && (h_nxt < 10'(HS_END)));
            vs_nxt    = !((v_nxt >= 10'(VS_START)) && (v_nxt < 10'(VS_END)));
            blank_nxt = (h_nxt < 10'(H_VIS)) && (v_nxt < 10'(V_VIS));
        end

        if (frame_end) begin
            fc_nxt = frame_count + 8'd1;
        end
    end

    // Scan state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            blank_n     <= 1'b1;
            frame_count <= '0;
        end else begin
            DrawX       <= h_nxt;
            DrawY       <= v_nxt;
            VGA_HS      <= hs_nxt;
            VGA_VS      <= vs_nxt;
            blank_n     <= blank_nxt;
            frame_count <= fc_nxt;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a full-size instance checked against hand-computed
// vectors over two lines, plus two reduced-geometry instances (PIX_DIV=2 and
// PIX_DIV=1) for frame timing, frame_count wrap and mid-frame reset.
module tb_vga_scan_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pe;
        logic       bl;
        logic       hs;
        logic       vs;
        logic       le;
        logic       fe;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int   k;      // Clk edges since reset release
        obs_t exp;
    } vec_t;

    logic Clk = 1'b0;
    always #10 Clk = ~Clk;

    logic rst_a, rst_b, rst_c;

    logic       pe_a, hs_a, vs_a, bl_a, le_a, fe_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       pe_b, hs_b, vs_b, bl_b, le_b, fe_b;
    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;
    logic       pe_c, hs_c, vs_c, bl_c, le_c, fe_c;
    logic [9:0] x_c, y_c;
    logic [7:0] fc_c;

    int errors = 0;
    int checks = 0;

    vga_scan_gen u_a (
        .Clk(Clk), .Reset(rst_a), .pix_en(pe_a), .DrawX(x_a), .DrawY(y_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .blank_n(bl_a), .line_end(le_a),
        .frame_end(fe_a), .frame_count(fc_a)
    );

    // Small geometry: H_TOTAL=15 (HS low 10..12), V_TOTAL=8 (VS low 5..6).
    vga_scan_gen #(
        .PIX_DIV(2), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_b (
        .Clk(Clk), .Reset(rst_b), .pix_en(pe_b), .DrawX(x_b), .DrawY(y_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .blank_n(bl_b), .line_end(le_b),
        .frame_end(fe_b), .frame_count(fc_b)
    );

    vga_scan_gen #(
        .PIX_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_c (
        .Clk(Clk), .Reset(rst_c), .pix_en(pe_c), .DrawX(x_c), .DrawY(y_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .blank_n(bl_c), .line_end(le_c),
        .frame_end(fe_c), .frame_count(fc_c)
    );

    function automatic obs_t obs_a();
        return '{x: x_a, y: y_a, pe: pe_a, bl: bl_a, hs: hs_a, vs: vs_a,
                 le: le_a, fe: fe_a, fc: fc_a};
    endfunction

    function automatic obs_t obs_b();
        return '{x: x_b, y: y_b, pe: pe_b, bl: bl_b, hs: hs_b, vs: vs_b,
                 le: le_b, fe: fe_b, fc: fc_b};
    endfunction

    function automatic obs_t obs_c();
        return '{x: x_c, y: y_c, pe: pe_c, bl: bl_c, hs: hs_c, vs: vs_c,
                 le: le_c, fe: fe_c, fc: fc_c};
    endfunction

    // Hand vector helper for the full-size instance (VS high, no frame_end, fc=0).
    function automatic obs_t mk(int x, int y, bit pe, bit bl, bit hs, bit le);
        obs_t o;
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.pe = pe;
        o.bl = bl;
        o.hs = hs;
        o.vs = 1'b1;
        o.le = le;
        o.fe = 1'b0;
        o.fc = 8'd0;
        return o;
    endfunction

    // Expected state of a small-geometry instance k edges after reset release.
    function automatic obs_t model_small(int k, int div);
        obs_t o;
        int p, h, v;
        p    = k / div;
        h    = p % 15;
        v    = (p / 15) % 8;
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.pe = ((k % div) == div - 1);
        o.bl = (h < 8) && (v < 4);
        o.hs = !((h >= 10) && (h < 13));
        o.vs = !((v >= 5) && (v < 7));
        o.le = o.pe && (h == 14);
        o.fe = o.le && (v == 7);
        o.fc = 8'((k / (div * 120)) % 256);
        return o;
    endfunction

    task automatic check_obs(input string name, input int k, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got x=%0d y=%0d pe=%b bl=%b hs=%b vs=%b le=%b fe=%b fc=%0d want x=%0d y=%0d pe=%b bl=%b hs=%b vs=%b le=%b fe=%b fc=%0d",
                     name, k, got.x, got.y, got.pe, got.bl, got.hs, got.vs, got.le, got.fe, got.fc,
                     exp.x, exp.y, exp.pe, exp.bl, exp.hs, exp.vs, exp.le, exp.fe, exp.fc);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    vec_t tbl[14];

    initial begin
        int   k;
        int   bad;
        int   bad_k;
        obs_t bad_got, bad_exp, e;

        // Full-size instance, PIX_DIV=2: DrawX = k/2, pix_en on odd k.
        tbl[0]  = '{1,    mk(0,   0, 1, 1, 1, 0)};
        tbl[1]  = '{2,    mk(1,   0, 0, 1, 1, 0)};
        tbl[2]  = '{1278, mk(639, 0, 0, 1, 1, 0)};
        tbl[3]  = '{1279, mk(639, 0, 1, 1, 1, 0)};
        tbl[4]  = '{1280, mk(640, 0, 0, 0, 1, 0)};
        tbl[5]  = '{1311, mk(655, 0, 1, 0, 1, 0)};
        tbl[6]  = '{1312, mk(656, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1503, mk(751, 0, 1, 0, 0, 0)};
        tbl[8]  = '{1504, mk(752, 0, 0, 0, 1, 0)};
        tbl[9]  = '{1598, mk(799, 0, 0, 0, 1, 0)};
        tbl[10] = '{1599, mk(799, 0, 1, 0, 1, 1)};
        tbl[11] = '{1600, mk(0,   1, 0, 1, 1, 0)};
        tbl[12] = '{3199, mk(799, 1, 1, 0, 1, 1)};
        tbl[13] = '{3200, mk(0,   2, 0, 1, 1, 0)};

        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        @(negedge Clk);
        repeat (3) tick();

        // Reset-held state.
        check_obs("reset_a", 0, obs_a(), mk(0, 0, 0, 1, 1, 0));
        check_obs("reset_c_pix_en", 0, obs_c(), model_small(0, 1));

        // Full-size vectors.
        rst_a = 1'b0;
        k = 0;
        for (int i = 0; i < 14; i++) begin
            while (k < tbl[i].k) begin
                tick();
                k++;
            end
            check_obs("vec_a", k, obs_a(), tbl[i].exp);
        end

        // PIX_DIV=1 stream: advance every Clk, HS low 3 Clk, frame 120 Clk.
        rst_c = 1'b0;
        bad = 0;
        bad_k = 0;
        bad_got = '0;
        bad_exp = '0;
        for (int kc = 0; kc <= 300; kc++) begin
            if (kc > 0) tick();
            e = model_small(kc, 1);
            if (kc == 0 || kc == 12 || kc == 13 || kc == 119 || kc == 120)
                check_obs("spot_c", kc, obs_c(), e);
            if (obs_c() !== e) begin
                if (bad == 0) begin
                    bad_k = kc;
                    bad_got = obs_c();
                    bad_exp = e;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_c bad_cycles=%0d want 0, first k=%0d got=%h want=%h",
                     bad, bad_k, bad_got, bad_exp);
        end

        // PIX_DIV=2 small stream through 257 frames (frame_count wrap).
        rst_b = 1'b0;
        bad = 0;
        bad_k = 0;
        bad_got = '0;
        bad_exp = '0;
        for (int kb = 0; kb <= 61882; kb++) begin
            if (kb > 0) tick();
            e = model_small(kb, 2);
            if (kb == 239 || kb == 240 || kb == 61439 || kb == 61440 || kb == 61882)
                check_obs("spot_b", kb, obs_b(), e);
            if (obs_b() !== e) begin
                if (bad == 0) begin
                    bad_k = kb;
                    bad_got = obs_b();
                    bad_exp = e;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_b bad_cycles=%0d want 0, first k=%0d got=%h want=%h",
                     bad, bad_k, bad_got, bad_exp);
        end

        // Now at (11,6): inside both sync pulses, frame_count=1. Reset mid-frame.
        rst_b = 1'b1;
        tick();
        check_obs("midreset_b_first_edge", 0, obs_b(), model_small(0, 2));
        repeat (2) tick();
        check_obs("midreset_b_held", 0, obs_b(), model_small(0, 2));
        rst_b = 1'b0;
        check_obs("release_b_k0", 0, obs_b(), model_small(0, 2));
        tick();
        check_obs("release_b_k1", 1, obs_b(), model_small(1, 2));
        tick();
        check_obs("release_b_k2", 2, obs_b(), model_small(2, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
